// File: rtl/operand_readout.sv
// Snapshots the four operand registers and the block result, then streams them out one nibble
// per word over a four-phase valid/ack handshake with an asynchronous host.
module operand_readout #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned TO_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] in4,
    input  logic [3:0] result,
    input  logic       ack,
    output logic [3:0] dout,
    output logic [2:0] tag,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StSend, StRelease, StFinish} state_e;

    localparam logic [TO_W-1:0] ToLast = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             shadow_q [5];
    logic [2:0]             idx_q, idx_d;
    logic [TO_W-1:0]        cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   capture;
    logic                   ack_s;
    logic                   to_hit;

    assign ack_s  = sync_q[SYNC_STAGES-1];
    assign to_hit = (TIMEOUT != 0) && (cnt_q == ToLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    capture = 1'b1;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (ack_s) begin
                    cnt_d   = '0;
                    state_d = StRelease;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StRelease: begin
                if (!ack_s) begin
                    cnt_d = '0;
                    if (idx_q == 3'd4) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Shadow copy keeps the frame immune to operand changes after the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) shadow_q[i] <= 4'd0;
        end else if (capture) begin
            shadow_q[0] <= in1;
            shadow_q[1] <= in2;
            shadow_q[2] <= in3;
            shadow_q[3] <= in4;
            shadow_q[4] <= result;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    dout = shadow_q[0];
            3'd1:    dout = shadow_q[1];
            3'd2:    dout = shadow_q[2];
            3'd3:    dout = shadow_q[3];
            default: dout = shadow_q[4];
        endcase
    end

    assign tag   = idx_q;
    assign valid = (state_q == StSend);
    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StFinish);
    assign err   = err_q;

endmodule

// File: tb/tb_operand_readout.sv
// Scoreboard bench for operand_readout: expected words are queued at start and checked as the
// host model reads each valid word.
module tb_operand_readout;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] in1, in2, in3, in4, result;
    logic       ack;
    logic [3:0] dout;
    logic [2:0] tag;
    logic       valid, busy, done, err;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int idle_cnt = 0;
    bit count_idle = 1'b0;
    logic [6:0] exp_q [$];

    operand_readout #(
        .SYNC_STAGES(2),
        .TIMEOUT    (8),
        .TO_W       (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .in4   (in4),
        .result(result),
        .ack   (ack),
        .dout  (dout),
        .tag   (tag),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (count_idle && busy === 1'b0) idle_cnt++;
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic wait_valid(input logic lvl);
        int n = 0;
        while (valid !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (valid !== lvl) check_val("valid_wait", {31'd0, valid}, {31'd0, lvl});
    endtask

    task automatic push_frame();
        exp_q.push_back({3'd0, in1});
        exp_q.push_back({3'd1, in2});
        exp_q.push_back({3'd2, in3});
        exp_q.push_back({3'd3, in4});
        exp_q.push_back({3'd4, result});
    endtask

    // Leaves start high when hold is set; returns at the first negedge of SEND.
    task automatic start_frame(input bit hold);
        @(negedge clk);
        start = 1'b1;
        push_frame();
        @(negedge clk);
        if (!hold) start = 1'b0;
        check_val("start_flags", {29'd0, valid, busy, err}, 32'b110);
    endtask

    task automatic see_word();
        logic [6:0] w;
        wait_valid(1'b1);
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7f;
        check_val("word", {25'd0, tag, dout}, {25'd0, w});
    endtask

    task automatic host_word();
        see_word();
        repeat (3) @(negedge clk);
        ack = 1'b1;
        wait_valid(1'b0);
        repeat (3) @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic set_ops(input logic [3:0] a, b, c, d, r);
        in1 = a; in2 = b; in3 = c; in4 = d; result = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        rst = 1'b1; start = 1'b0; ack = 1'b0;
        set_ops(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        check_val("reset", {20'd0, dout, tag, valid, busy, done, err}, 32'd0);
        rst = 1'b0;

        // Basic frame
        set_ops(4'h1, 4'h2, 4'h3, 4'h4, 4'hA);
        start_frame(1'b0);
        repeat (5) host_word();
        repeat (8) @(negedge clk);
        check_val("basic_done", done_cnt, 1);
        check_val("basic_end", {30'd0, busy, err}, 32'd0);

        // Snapshot: in1 changes right after the start edge
        set_ops(4'h5, 4'h6, 4'h7, 4'h8, 4'h9);
        start_frame(1'b0);
        in1 = 4'hF;
        repeat (5) host_word();
        repeat (8) @(negedge clk);
        check_val("snap_done", done_cnt, 2);

        // No ack: SEND times out after 8 valid cycles
        d0 = done_cnt;
        start_frame(1'b0);
        exp_q.delete();
        n = 0;
        while (valid === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_val("to_valid_cycles", n, 8);
        check_val("to_flags", {29'd0, valid, busy, err}, 32'b001);

        // New start clears err; stuck ack then times out in RELEASE
        start_frame(1'b0);
        see_word();
        @(negedge clk);
        ack = 1'b1;
        n = 0;
        while (err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("stuck_flags", {26'd0, err, valid, busy, tag}, {26'd0, 6'b100000});
        check_val("to_no_done", done_cnt, d0);
        ack = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);

        // Reset while tag 2 is valid
        set_ops(4'h3, 4'hC, 4'h6, 4'h9, 4'h1);
        d0 = done_cnt;
        start_frame(1'b0);
        repeat (2) host_word();
        see_word();
        rst = 1'b1;
        #1;
        check_val("rst_mid", {20'd0, dout, tag, valid, busy, done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_val("rst_no_done", done_cnt, d0);
        set_ops(4'h9, 4'h8, 4'h7, 4'h6, 4'h5);
        start_frame(1'b0);
        repeat (5) host_word();
        repeat (8) @(negedge clk);
        check_val("rst_frame_done", done_cnt, d0 + 1);

        // start held and ack pre-asserted: two back-to-back frames
        set_ops(4'hE, 4'hD, 4'hB, 4'h2, 4'h0);
        d0 = done_cnt;
        @(negedge clk);
        ack = 1'b1;
        start_frame(1'b1);
        count_idle = 1'b1;
        push_frame();
        repeat (10) host_word();
        start = 1'b0;
        count_idle = 1'b0;
        repeat (8) @(negedge clk);
        check_val("b2b_done", done_cnt, d0 + 2);
        check_val("b2b_idle", idle_cnt, 1);
        check_val("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
